// File: rtl/spi_slave.sv
// SPI responder running entirely in the system clock domain: oversampled sclk/cs_n/mosi,
// all four CPOL/CPHA modes, selectable bit order, back-to-back frames under one chip select.
module spi_slave #(
    parameter int NBITS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             lsb_first,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [NBITS-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [NBITS-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             tx_underrun,
    output logic             frame_error
);

    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   cpol_l, cpha_l, lsb_l;
    logic [NBITS-1:0]       tx_shift, rx_shift, tx_buf;
    logic                   tx_full, reload_pending, first_lead;
    logic [CW-1:0]          bit_cnt;

    logic             sclk_s, cs_s, mosi_s;
    logic             lead_edge, trail_edge, cs_fall, cs_rise, active;
    logic             do_sample, do_advance, do_load, handshake;
    logic [NBITS-1:0] buf_word, rx_next, tx_next;

    // cs_n synchronizer resets to the deselected level so reset never fakes a CS assertion
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        sclk_s     = sclk_sync[SYNC_STAGES-1];
        cs_s       = cs_sync[SYNC_STAGES-1];
        mosi_s     = mosi_sync[SYNC_STAGES-1];
        lead_edge  = (sclk_s != sclk_d) && (sclk_s != cpol_l);
        trail_edge = (sclk_s != sclk_d) && (sclk_s == cpol_l);
        cs_fall    = cs_d && !cs_s;
        cs_rise    = !cs_d && cs_s;
        active     = (state == SHIFT) && !cs_rise;
        do_sample  = active && (cpha_l ? trail_edge : lead_edge);
        do_advance = active && (cpha_l ? lead_edge : trail_edge) && !first_lead;
        do_load    = ((state == IDLE) && cs_fall) || (do_advance && reload_pending);
        handshake  = tx_valid && !tx_full;
        buf_word   = tx_full ? tx_buf : '0;
        rx_next    = lsb_l ? {mosi_s, rx_shift[NBITS-1:1]} : {rx_shift[NBITS-2:0], mosi_s};
        tx_next    = lsb_l ? {1'b0, tx_shift[NBITS-1:1]} : {tx_shift[NBITS-2:0], 1'b0};
    end

    assign tx_ready = !tx_full;
    assign miso     = miso_oe & (lsb_l ? tx_shift[0] : tx_shift[NBITS-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cpol_l         <= 1'b0;
            cpha_l         <= 1'b0;
            lsb_l          <= 1'b0;
            tx_shift       <= '0;
            rx_shift       <= '0;
            tx_buf         <= '0;
            tx_full        <= 1'b0;
            reload_pending <= 1'b0;
            first_lead     <= 1'b0;
            bit_cnt        <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            miso_oe        <= 1'b0;
            busy           <= 1'b0;
            tx_underrun    <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_error <= 1'b0;

            // A handshake in the same cycle as a load refills the buffer, keeping it full
            if (handshake) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (do_load) begin
                tx_full <= 1'b0;
            end

            if (do_load) begin
                tx_shift <= buf_word;
                if (!tx_full)
                    tx_underrun <= 1'b1;
            end else if (do_advance) begin
                tx_shift <= tx_next;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        cpol_l         <= cpol;
                        cpha_l         <= cpha;
                        lsb_l          <= lsb_first;
                        bit_cnt        <= '0;
                        rx_shift       <= '0;
                        reload_pending <= 1'b0;
                        first_lead     <= cpha;
                        miso_oe        <= 1'b1;
                        busy           <= 1'b1;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt != '0)
                            frame_error <= 1'b1;
                        bit_cnt <= '0;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (lead_edge && first_lead)
                            first_lead <= 1'b0;
                        if (do_advance)
                            reload_pending <= 1'b0;
                        // Sample and advance fall on opposite edges, so they never coincide
                        if (do_sample) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == CW'(NBITS - 1)) begin
                                rx_data        <= rx_next;
                                rx_valid       <= 1'b1;
                                bit_cnt        <= '0;
                                reload_pending <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives table vectors in all modes,
// plus hand-written back-to-back, underrun, abort and mid-frame reset sequences.
module tb_spi_slave;

    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_error;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    int checks_total = 0;
    int checks_passed = 0;

    int         rx_cnt = 0, underrun_cnt = 0, ferr_cnt = 0;
    logic [7:0] rx_first = 8'h00, rx_last = 8'h00;

    typedef struct {
        logic [1:0] mode;
        logic       lsb;
        logic [7:0] slave_word;
        logic [7:0] master_word;
    } vec_t;

    vec_t vecs[8];

    spi_slave #(.NBITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Count strobe cycles and remember the last two received words
    always @(posedge clk) begin
        if (rx_valid) begin
            rx_cnt   = rx_cnt + 1;
            rx_first = rx_last;
            rx_last  = rx_data;
        end
        if (tx_underrun) underrun_cnt = underrun_cnt + 1;
        if (frame_error) ferr_cnt = ferr_cnt + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic loadBuffer(input logic [7:0] d);
        @(negedge clk);
        checkOutput("tx_ready_empty", 16'(tx_ready), 16'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("tx_ready_full", 16'(tx_ready), 16'd0);
    endtask

    // Behavioural SPI master: one CS window, nsend bits taken from mdata (width bits wide)
    task automatic applyStimulus(input logic [1:0] mode, input logic lsb, input logic [15:0] mdata,
                                 input int width, input int nsend, output logic [15:0] mrx);
        logic pol, pha, b, got;
        pol = mode[1];
        pha = mode[0];
        mrx = '0;
        got = 1'b0;
        @(negedge clk);
        cpol = pol; cpha = pha; lsb_first = lsb; sclk = pol; mosi = 1'b0;
        repeat (HP) @(negedge clk);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nsend; i++) begin
            b = lsb ? mdata[i] : mdata[width-1-i];
            if (!pha) begin
                mosi = b;
                repeat (HP) @(negedge clk);
                sclk = ~pol;
                got  = miso;
                repeat (HP) @(negedge clk);
                sclk = pol;
            end else begin
                sclk = ~pol;
                mosi = b;
                repeat (HP) @(negedge clk);
                sclk = pol;
                got  = miso;
                repeat (HP) @(negedge clk);
            end
            if (lsb) mrx[i] = got;
            else mrx = {mrx[14:0], got};
        end
        repeat (HP) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    initial begin
        logic [15:0] mrx;
        int          rx0, ur0, fe0;

        vecs[0] = '{2'd0, 1'b0, 8'h7B, 8'hA5};
        vecs[1] = '{2'd1, 1'b0, 8'h3C, 8'hE9};
        vecs[2] = '{2'd2, 1'b0, 8'hF9, 8'hDB};
        vecs[3] = '{2'd3, 1'b0, 8'h21, 8'h48};
        vecs[4] = '{2'd0, 1'b1, 8'h7B, 8'hA5};
        vecs[5] = '{2'd1, 1'b1, 8'h3C, 8'hE9};
        vecs[6] = '{2'd2, 1'b1, 8'hF9, 8'hDB};
        vecs[7] = '{2'd3, 1'b1, 8'h21, 8'h48};

        repeat (4) @(negedge clk);
        checkOutput("rst_miso", 16'(miso), 16'd0);
        checkOutput("rst_miso_oe", 16'(miso_oe), 16'd0);
        checkOutput("rst_rx_data", 16'(rx_data), 16'h00);
        checkOutput("rst_rx_valid", 16'(rx_valid), 16'd0);
        checkOutput("rst_tx_ready", 16'(tx_ready), 16'd1);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_tx_underrun", 16'(tx_underrun), 16'd0);
        checkOutput("rst_frame_error", 16'(frame_error), 16'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            loadBuffer(vecs[v].slave_word);
            rx0 = rx_cnt;
            applyStimulus(vecs[v].mode, vecs[v].lsb, {8'h00, vecs[v].master_word}, 8, 8, mrx);
            checkOutput($sformatf("v%0d_master_rx", v), {8'h00, mrx[7:0]}, {8'h00, vecs[v].slave_word});
            checkOutput($sformatf("v%0d_slave_rx", v), 16'(rx_data), {8'h00, vecs[v].master_word});
            checkOutput($sformatf("v%0d_rx_pulses", v), 16'(rx_cnt - rx0), 16'd1);
            checkOutput($sformatf("v%0d_tx_ready", v), 16'(tx_ready), 16'd1);
        end

        // Abort after 5 bits: partial word discarded, rx_data keeps 0x48
        rx0 = rx_cnt; fe0 = ferr_cnt;
        applyStimulus(2'd0, 1'b0, 16'h00A5, 8, 5, mrx);
        checkOutput("abort_frame_error", 16'(ferr_cnt - fe0), 16'd1);
        checkOutput("abort_no_rx_valid", 16'(rx_cnt - rx0), 16'd0);
        checkOutput("abort_rx_held", 16'(rx_data), 16'h48);
        loadBuffer(8'h96);
        rx0 = rx_cnt; fe0 = ferr_cnt;
        applyStimulus(2'd0, 1'b0, 16'h003C, 8, 8, mrx);
        checkOutput("after_abort_slave_rx", 16'(rx_data), 16'h3C);
        checkOutput("after_abort_master_rx", {8'h00, mrx[7:0]}, 16'h96);
        checkOutput("after_abort_rx_pulses", 16'(rx_cnt - rx0), 16'd1);
        checkOutput("after_abort_no_ferr", 16'(ferr_cnt - fe0), 16'd0);

        // Underrun: nothing loaded before CS
        rx0 = rx_cnt; ur0 = underrun_cnt;
        checkOutput("underrun_buf_empty", 16'(tx_ready), 16'd1);
        applyStimulus(2'd1, 1'b0, 16'h00A5, 8, 8, mrx);
        checkOutput("underrun_pulses", 16'(underrun_cnt - ur0), 16'd1);
        checkOutput("underrun_master_rx", {8'h00, mrx[7:0]}, 16'h00);
        checkOutput("underrun_slave_rx", 16'(rx_data), 16'hA5);
        checkOutput("underrun_rx_pulses", 16'(rx_cnt - rx0), 16'd1);

        // Back-to-back: second word written while the first frame is shifting
        loadBuffer(8'h11);
        rx0 = rx_cnt; ur0 = underrun_cnt;
        fork
            applyStimulus(2'd1, 1'b0, 16'hC35A, 16, 16, mrx);
            begin
                repeat (40) @(negedge clk);
                checkOutput("b2b_tx_ready_mid", 16'(tx_ready), 16'd1);
                tx_data  = 8'h22;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        checkOutput("b2b_master_rx", mrx, 16'h1122);
        checkOutput("b2b_rx_pulses", 16'(rx_cnt - rx0), 16'd2);
        checkOutput("b2b_first_word", 16'(rx_first), 16'hC3);
        checkOutput("b2b_second_word", 16'(rx_last), 16'h5A);
        checkOutput("b2b_no_underrun", 16'(underrun_cnt - ur0), 16'd0);

        // Synchronous reset in the middle of a frame with a full buffer
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sclk = 1'b0;
        repeat (HP) @(negedge clk);
        cs_n = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("pre_reset_busy", 16'(busy), 16'd1);
        checkOutput("pre_reset_miso_oe", 16'(miso_oe), 16'd1);
        checkOutput("pre_reset_tx_ready", 16'(tx_ready), 16'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_miso", 16'(miso), 16'd0);
        checkOutput("mid_rst_miso_oe", 16'(miso_oe), 16'd0);
        checkOutput("mid_rst_rx_data", 16'(rx_data), 16'h00);
        checkOutput("mid_rst_rx_valid", 16'(rx_valid), 16'd0);
        checkOutput("mid_rst_tx_ready", 16'(tx_ready), 16'd1);
        checkOutput("mid_rst_busy", 16'(busy), 16'd0);
        checkOutput("mid_rst_tx_underrun", 16'(tx_underrun), 16'd0);
        checkOutput("mid_rst_frame_error", 16'(frame_error), 16'd0);
        reset = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (4 * HP) @(negedge clk);

        loadBuffer(8'h7B);
        rx0 = rx_cnt;
        applyStimulus(2'd0, 1'b0, 16'h00A5, 8, 8, mrx);
        checkOutput("post_reset_master_rx", {8'h00, mrx[7:0]}, 16'h7B);
        checkOutput("post_reset_slave_rx", 16'(rx_data), 16'hA5);
        checkOutput("post_reset_rx_pulses", 16'(rx_cnt - rx0), 16'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
